ssd_scan_driver: RTL and testbench

//   Downstream consumer of the 2-bit SSD scan select produced by the clock divider.

---
 rtl/ssd_scan_driver_if.sv | 35 +++
 rtl/ssd_scan_driver.sv | 214 +++++++++++++++++++++
 tb/tb_ssd_scan_driver.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssd_scan_driver_if.sv
// Bus bundle between the scan driver and whoever feeds it digits and scan indices.
// The master side supplies scan index, digit data and load requests; the slave side
// (the driver) returns the load handshake, the display drive lines and the frame pulse.
interface ssd_scan_driver_if;
  logic [1:0]  scan_sel;
  logic [15:0] digit_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        load_ack;
  logic [3:0]  ssd_ctl;
  logic [7:0]  ssd_seg;
  logic        frame_done;

  modport master (
    output scan_sel,
    output digit_in,
    output dp_in,
    output load,
    input  load_ack,
    input  ssd_ctl,
    input  ssd_seg,
    input  frame_done
  );

  modport slave (
    input  scan_sel,
    input  digit_in,
    input  dp_in,
    input  load,
    output load_ack,
    output ssd_ctl,
    output ssd_seg,
    output frame_done
  );
endinterface

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment driver.
// Follows the divider's scan index, blanks the bus for BLANK_CYCLES clocks after every
// index change, and double-buffers digit data (staging -> shadow) so a new value is
// only ever committed at the 3->0 frame wrap.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zeros on d3..d1.
// BLANK_CYCLES is meant to stay within 1..15 (4-bit blank counter).
module ssd_scan_driver #(
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic              clk_in,
  input  logic              rst,
  ssd_scan_driver_if.slave  ssd_if
);

  typedef enum logic {
    SHOW,
    BLANK
  } state_t;

  // Counter reload value: the counter counts down to zero, so it holds one less than
  // the number of dark cycles.
  localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

  // Segment patterns for a..g only (dp handled separately), active low.
  function automatic logic [6:0] hexToSeg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'h01;
      4'h1:    seg = 7'h4F;
      4'h2:    seg = 7'h12;
      4'h3:    seg = 7'h06;
      4'h4:    seg = 7'h4C;
      4'h5:    seg = 7'h24;
      4'h6:    seg = 7'h20;
      4'h7:    seg = 7'h0F;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h04;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h60;
      4'hC:    seg = 7'h31;
      4'hD:    seg = 7'h42;
      4'hE:    seg = 7'h30;
      default: seg = 7'h38;
    endcase
    return seg;
  endfunction

  // Registered state
  state_t      state_q;
  logic [3:0]  blankCnt_q;
  logic [1:0]  sel_q;
  logic [19:0] staging_q;
  logic [19:0] shadow_q;
  logic        pending_q;
  logic        loadAck_q;
  logic        frameDone_q;
  logic [3:0]  ctl_q;
  logic [7:0]  seg_q;

  // Next-state values for the double buffer
  logic [19:0] staging_d;
  logic [19:0] shadow_d;
  logic        pending_d;

  // Per-cycle decisions
  logic        selChange;
  logic        frameWrap;
  logic        loadAccept;

  // Display pattern for the currently selected digit
  logic [3:0]  curDigit;
  logic        curDp;
  logic [3:0]  leadZero;
  logic [3:0]  dispCtl;
  logic [7:0]  dispSeg;

  // Detect index changes and the single 3->0 wrap; a load is taken when nothing is
  // pending, or when the wrap in this same cycle frees the staging register.
  always_comb begin
    selChange  = (ssd_if.scan_sel != sel_q);
    frameWrap  = (sel_q == 2'd3) && (ssd_if.scan_sel == 2'd0);
    loadAccept = ssd_if.load && (!pending_q || frameWrap);
  end

  // Double-buffer update: commit the old staging at the wrap, then capture new data.
  always_comb begin
    staging_d = staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (frameWrap && pending_q) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
    end
    if (loadAccept) begin
      staging_d = {ssd_if.dp_in, ssd_if.digit_in};
      pending_d = 1'b1;
    end
  end

  // Leading-zero map: a digit is suppressed when it and every higher digit are zero.
`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    leadZero    = 4'b0000;
    leadZero[3] = (shadow_q[15:12] == 4'h0);
    leadZero[2] = leadZero[3] && (shadow_q[11:8] == 4'h0);
    leadZero[1] = leadZero[2] && (shadow_q[7:4] == 4'h0);
    leadZero[0] = 1'b0;
  end
`else
  always_comb begin
    leadZero = 4'b0000;
  end
`endif

  // Pick the shadow digit for the current index and build its enable and segments.
  always_comb begin
    curDigit = 4'h0;
    curDp    = 1'b0;
    case (sel_q)
      2'd0: begin
        curDigit = shadow_q[3:0];
        curDp    = shadow_q[16];
      end
      2'd1: begin
        curDigit = shadow_q[7:4];
        curDp    = shadow_q[17];
      end
      2'd2: begin
        curDigit = shadow_q[11:8];
        curDp    = shadow_q[18];
      end
      default: begin
        curDigit = shadow_q[15:12];
        curDp    = shadow_q[19];
      end
    endcase
    dispCtl = ~(4'b0001 << sel_q);
    if (leadZero[sel_q]) begin
      dispSeg = {7'h7F, ~curDp};
    end else begin
      dispSeg = {hexToSeg(curDigit), ~curDp};
    end
  end

  // Scan index tracking, double buffer registers and handshake pulses.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      sel_q       <= 2'd0;
      staging_q   <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      loadAck_q   <= 1'b0;
      frameDone_q <= 1'b0;
    end else begin
      sel_q       <= ssd_if.scan_sel;
      staging_q   <= staging_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      loadAck_q   <= loadAccept;
      frameDone_q <= frameWrap;
    end
  end

  // Blanking FSM with registered display outputs; a change during blanking restarts it.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q    <= SHOW;
      blankCnt_q <= 4'd0;
      ctl_q      <= 4'hF;
      seg_q      <= 8'hFF;
    end else begin
      case (state_q)
        SHOW: begin
          if (selChange) begin
            state_q    <= BLANK;
            blankCnt_q <= BLANK_LOAD;
            ctl_q      <= 4'hF;
            seg_q      <= 8'hFF;
          end else begin
            ctl_q <= dispCtl;
            seg_q <= dispSeg;
          end
        end
        BLANK: begin
          if (selChange) begin
            blankCnt_q <= BLANK_LOAD;
            ctl_q      <= 4'hF;
            seg_q      <= 8'hFF;
          end else if (blankCnt_q == 4'd0) begin
            state_q <= SHOW;
            ctl_q   <= dispCtl;
            seg_q   <= dispSeg;
          end else begin
            blankCnt_q <= blankCnt_q - 4'd1;
            ctl_q      <= 4'hF;
            seg_q      <= 8'hFF;
          end
        end
        default: begin
          state_q    <= SHOW;
          blankCnt_q <= 4'd0;
          ctl_q      <= 4'hF;
          seg_q      <= 8'hFF;
        end
      endcase
    end
  end

  assign ssd_if.load_ack   = loadAck_q;
  assign ssd_if.frame_done = frameDone_q;
  assign ssd_if.ssd_ctl    = ctl_q;
  assign ssd_if.ssd_seg    = seg_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Testbench for ssd_scan_driver: directed scenarios followed by a randomized scan/load
// phase, every cycle compared against a timeline-level model of the display.
module tb_ssd_scan_driver;

  localparam int unsigned TB_BLANK = 1;

  logic clk_in = 1'b0;
  logic rst;

  ssd_scan_driver_if bus ();

  ssd_scan_driver #(
    .BLANK_CYCLES (TB_BLANK)
  ) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .ssd_if (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  int assertsDone = 0;
  int failures    = 0;

  // Segment codes with dp off, indexed by hex value
  logic [7:0] segTable [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  // Reference model: what has been accepted, what is on display, and how long ago
  // the scan index last moved.
  logic [1:0]  mSel;
  logic [15:0] mStageVal;
  logic [3:0]  mStageDp;
  logic [15:0] mShownVal;
  logic [3:0]  mShownDp;
  bit          mPending;
  int          mSince;
  bit          expAck;
  bit          expDone;

  function automatic logic [7:0] expSeg(input logic [15:0] v, input logic [3:0] dp, input int idx);
    logic [7:0] s;
    logic [3:0] d;
    d = v[idx*4 +: 4];
    s = segTable[d];
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (v >> (idx*4)) == 16'h0000) s = 8'hFF;
`endif
    if (dp[idx]) s[0] = 1'b0;
    return s;
  endfunction

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertsDone++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mSel      = 2'd0;
    mStageVal = 16'h0;
    mStageDp  = 4'h0;
    mShownVal = 16'h0;
    mShownDp  = 4'h0;
    mPending  = 1'b0;
    mSince    = 1000;
    expAck    = 1'b0;
    expDone   = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkVal({tag, " ctl"},  8'(bus.ssd_ctl),    8'h0F);
    checkVal({tag, " seg"},  bus.ssd_seg,         8'hFF);
    checkVal({tag, " ack"},  8'(bus.load_ack),   8'h00);
    checkVal({tag, " done"}, 8'(bus.frame_done), 8'h00);
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] eCtl;
    logic [7:0] eSeg;
    if (mSince < int'(TB_BLANK)) begin
      eCtl = 4'hF;
      eSeg = 8'hFF;
    end else begin
      eCtl = ~(4'b0001 << mSel);
      eSeg = expSeg(mShownVal, mShownDp, int'(mSel));
    end
    checkVal({tag, " ctl"},  8'(bus.ssd_ctl),    8'(eCtl));
    checkVal({tag, " seg"},  bus.ssd_seg,         eSeg);
    checkVal({tag, " ack"},  8'(bus.load_ack),   8'(expAck));
    checkVal({tag, " done"}, 8'(bus.frame_done), 8'(expDone));
  endtask

  // One clock: update the model from the inputs seen at the edge, then check at negedge.
  task automatic tick(input string tag);
    bit change;
    bit wrap;
    bit accept;
    @(posedge clk_in);
    change = (bus.scan_sel != mSel);
    wrap   = (mSel == 2'd3) && (bus.scan_sel == 2'd0);
    accept = bus.load && (!mPending || wrap);
    if (wrap && mPending) begin
      mShownVal = mStageVal;
      mShownDp  = mStageDp;
      mPending  = 1'b0;
    end
    if (accept) begin
      mStageVal = bus.digit_in;
      mStageDp  = bus.dp_in;
      mPending  = 1'b1;
    end
    expAck  = accept;
    expDone = wrap;
    mSel    = bus.scan_sel;
    if (change) mSince = 0;
    else if (mSince < 1000) mSince++;
    @(negedge clk_in);
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input logic [1:0] sel, input logic ld, input logic [15:0] v, input logic [3:0] dp);
    bus.scan_sel = sel;
    bus.load     = ld;
    bus.digit_in = v;
    bus.dp_in    = dp;
  endtask

  task automatic scanStep(input logic [1:0] sel, input int hold);
    bus.scan_sel = sel;
    for (int i = 0; i < hold; i++) tick("scan");
  endtask

  // Requester-style load: hold load until acknowledged, bounded.
  task automatic holdLoad(input logic [15:0] v, input logic [3:0] dp);
    int n;
    bit got;
    n   = 0;
    got = 1'b0;
    bus.load     = 1'b1;
    bus.digit_in = v;
    bus.dp_in    = dp;
    while (!got && n < 8) begin
      tick("load");
      got = (bus.load_ack === 1'b1);
      n++;
    end
    bus.load = 1'b0;
    assertsDone++;
    assert (got) else begin
      failures++;
      $error("[TB] FAIL loadTimeout: observed ack=%0d expected 1", got);
    end
  endtask

  task automatic scanFrame(input int hold);
    scanStep(2'd1, hold);
    scanStep(2'd2, hold);
    scanStep(2'd3, hold);
    scanStep(2'd0, hold);
  endtask

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, then randomized scanning with random load pulses
  initial begin
    modelReset();
    rst = 1'b0;
    applyStimulus(2'd0, 1'b0, 16'h0, 4'h0);

    // Reset held for three clocks
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      checkResetOutputs("reset");
    end
    rst = 1'b1;
    tick("idle");
    tick("idle");

    // Load 1234 and scan two full frames
    $display("[TB] load 1234 and scan");
    holdLoad(16'h1234, 4'h0);
    scanFrame(3);
    scanFrame(3);
    checkVal("t2 idx0 ctl", 8'(bus.ssd_ctl), 8'h0E);
    checkVal("t2 idx0 seg", bus.ssd_seg, 8'h99);
    scanStep(2'd3, 3);
    checkVal("t2 idx3 ctl", 8'(bus.ssd_ctl), 8'h07);
    checkVal("t2 idx3 seg", bus.ssd_seg, 8'h9F);
    scanStep(2'd0, 1);
    checkVal("t2 blank ctl", 8'(bus.ssd_ctl), 8'h0F);
    tick("t2 after blank");

    // Second load while pending is ignored
    $display("[TB] load while pending");
    holdLoad(16'hAAAA, 4'h0);
    applyStimulus(2'd0, 1'b1, 16'h5555, 4'h0);
    tick("t3 second load");
    checkVal("t3 no ack", 8'(bus.load_ack), 8'h00);
    bus.load = 1'b0;
    tick("t3 hold");
    checkVal("t3 old shown", bus.ssd_seg, 8'h99);
    scanFrame(2);
    checkVal("t3 new shown", bus.ssd_seg, 8'h11);
    scanFrame(2);
    checkVal("t3 5555 dropped", bus.ssd_seg, 8'h11);

    // Load coincident with a wrap while pending
    $display("[TB] load at wrap");
    holdLoad(16'h8888, 4'h2);
    scanStep(2'd1, 2);
    scanStep(2'd2, 2);
    scanStep(2'd3, 2);
    applyStimulus(2'd0, 1'b1, 16'h0007, 4'h0);
    tick("t4 wrap load");
    checkVal("t4 ack", 8'(bus.load_ack), 8'h01);
    checkVal("t4 done", 8'(bus.frame_done), 8'h01);
    bus.load = 1'b0;
    tick("t4 show");
    checkVal("t4 old staging", bus.ssd_seg, 8'h01);
    scanFrame(2);
    checkVal("t4 0007 idx0", bus.ssd_seg, 8'h1F);
    scanStep(2'd3, 2);
`ifdef LEADING_ZERO_BLANK_EN
    checkVal("t4 0007 idx3", bus.ssd_seg, 8'hFF);
`else
    checkVal("t4 0007 idx3", bus.ssd_seg, 8'h03);
`endif

    // Leading zero handling on 0070
    $display("[TB] value 0070");
    scanStep(2'd1, 2);
    holdLoad(16'h0070, 4'h0);
    scanStep(2'd2, 2);
    scanStep(2'd3, 2);
    scanStep(2'd0, 2);
    checkVal("t5 d0", bus.ssd_seg, 8'h03);
    scanStep(2'd1, 2);
    checkVal("t5 d1", bus.ssd_seg, 8'h1F);
    scanStep(2'd2, 2);
`ifdef LEADING_ZERO_BLANK_EN
    checkVal("t5 d2", bus.ssd_seg, 8'hFF);
`else
    checkVal("t5 d2", bus.ssd_seg, 8'h03);
`endif
    scanStep(2'd3, 2);
`ifdef LEADING_ZERO_BLANK_EN
    checkVal("t5 d3", bus.ssd_seg, 8'hFF);
`else
    checkVal("t5 d3", bus.ssd_seg, 8'h03);
`endif

    // Reset during blanking with a pending load
    $display("[TB] reset during blank");
    scanStep(2'd1, 2);
    holdLoad(16'h9999, 4'hF);
    bus.scan_sel = 2'd2;
    @(posedge clk_in);
    #2 rst = 1'b0;
    #1 checkResetOutputs("t6 async");
    modelReset();
    @(negedge clk_in);
    rst = 1'b1;
    scanStep(2'd2, 2);
    scanStep(2'd3, 2);
    scanStep(2'd0, 1);
    checkVal("t6 wrap done", 8'(bus.frame_done), 8'h01);
    tick("t6 show");
    checkVal("t6 no commit", bus.ssd_seg, 8'h03);

    // Reset while a digit is lit takes effect before the next edge
    #2 rst = 1'b0;
    #1 checkResetOutputs("t6b async");
    modelReset();
    @(negedge clk_in);
    rst = 1'b1;
    tick("t6b resume");

    // Randomized scanning with sporadic load pulses
    $display("[TB] random phase");
    for (int it = 0; it < 300; it++) begin
      logic [1:0] nextSel;
      int hold;
      if ($urandom_range(0, 1) == 0) nextSel = mSel + 2'd1;
      else nextSel = 2'($urandom_range(0, 3));
      hold = int'($urandom_range(1, 4));
      bus.scan_sel = nextSel;
      for (int h = 0; h < hold; h++) begin
        bus.load     = ($urandom_range(0, 5) == 0);
        bus.digit_in = 16'($urandom);
        bus.dp_in    = 4'($urandom);
        tick("random");
      end
      bus.load = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertsDone, failures);
    $finish;
  end

endmodule
